sys_irq_ctrl: RTL and testbench

Interrupt aggregation controller that sits directly downstream of the system peripherals, including the system clock timer and its irq output. It synchronises up to 16 raw interrupt lines and latches each as edge- or level-triggered. Each line is masked and tracked by a pending/in-service pair. The block presents one prioritised irq to the CPU and a 16-bit Avalon-MM slave register file on the same address/chipselect/write_n/writedata/readdata scheme as the other system peripherals.

---
 rtl/sys_irq_pkg.sv | 26 ++
 rtl/sys_irq_sync.sv | 33 +++
 rtl/sys_irq_ctrl.sv | 97 +++++++++
 tb/tb_sys_irq_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sys_irq_pkg.sv
// sys_irq_pkg: register addresses, ACK read-word layout and priority encoder
package sys_irq_pkg;
    localparam logic [2:0] ADDR_PENDING    = 3'd0;
    localparam logic [2:0] ADDR_MASK       = 3'd1;
    localparam logic [2:0] ADDR_MODE       = 3'd2;
    localparam logic [2:0] ADDR_ACK        = 3'd3;
    localparam logic [2:0] ADDR_EOI        = 3'd4;
    localparam logic [2:0] ADDR_IN_SERVICE = 3'd5;
    localparam int ACK_VALID_BIT = 15;
    localparam int ACK_IDX_LSB   = 0;
    localparam int ACK_IDX_W     = 4;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } prio_t;

    function automatic prio_t prio_enc(input logic [15:0] v);
        prio_t r;
        r = '0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) r.idx = 4'(i);
        r.valid = |v;
        return r;
    endfunction
endpackage

// File: rtl/sys_irq_sync.sv
// sys_irq_sync: per-bit multi-stage synchroniser with edge-history flop
module sys_irq_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);
    logic [STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]             hist_q, hist_d;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++)
            sync_d[i] = sync_q[i-1];
        level  = sync_q[STAGES-1];
        hist_d = level;
        rise   = level & ~hist_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end
endmodule

// File: rtl/sys_irq_ctrl.sv
// sys_irq_ctrl: edge/level interrupt aggregator with mask, pending/in-service
// nesting and an Avalon-MM register file
module sys_irq_ctrl
    import sys_irq_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);
    logic [NUM_IRQ-1:0] s, rise;
    logic [NUM_IRQ-1:0] pending_q, pending_d, mask_q, mask_d, mode_q, mode_d;
    logic [NUM_IRQ-1:0] insvc_q, insvc_d;
    logic [NUM_IRQ-1:0] wdat, w1c, ack_vec, eoi_vec, below;
    logic [15:0]        readdata_q, readdata_d;
    logic [15:0]        pend16, mask16, mode16, insvc16, ack_word;
    logic               irq_q, irq_d, wr, blk;
    prio_t              pe;

    sys_irq_sync #(.W(NUM_IRQ), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (irq_in),
        .level (s),
        .rise  (rise)
    );

    always_comb begin
        wr      = chipselect & ~write_n;
        wdat    = writedata[NUM_IRQ-1:0];
        mask_d  = (wr && address == ADDR_MASK) ? wdat : mask_q;
        mode_d  = (wr && address == ADDR_MODE) ? wdat : mode_q;
        w1c     = (wr && address == ADDR_PENDING) ? wdat : '0;
        ack_vec = '0;
        eoi_vec = '0;
        pending_d = '0;
        below   = '0;
        blk     = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_vec[i] = wr && address == ADDR_ACK && writedata[3:0] == 4'(i);
            eoi_vec[i] = wr && address == ADDR_EOI && writedata[3:0] == 4'(i);
            // a new rise always beats a same-cycle clear; level->edge switch starts clean
            pending_d[i] = mode_q[i] ? (rise[i] | (pending_q[i] & ~w1c[i] & ~ack_vec[i]))
                         : (mode_d[i] ? rise[i] : s[i]);
            blk      = blk | insvc_q[i];
            below[i] = ~blk;
        end
        insvc_d = (insvc_q | ack_vec) & ~eoi_vec;
        irq_d   = |(pending_q & mask_q & below);
        pend16  = '0;
        mask16  = '0;
        mode16  = '0;
        insvc16 = '0;
        pend16[NUM_IRQ-1:0]  = pending_q;
        mask16[NUM_IRQ-1:0]  = mask_q;
        mode16[NUM_IRQ-1:0]  = mode_q;
        insvc16[NUM_IRQ-1:0] = insvc_q;
        pe       = prio_enc(pend16 & mask16);
        ack_word = '0;
        ack_word[ACK_VALID_BIT] = pe.valid;
        ack_word[ACK_IDX_LSB +: ACK_IDX_W] = pe.idx;
        readdata_d = address == ADDR_PENDING    ? pend16  :
                     address == ADDR_MASK       ? mask16  :
                     address == ADDR_MODE       ? mode16  :
                     address == ADDR_ACK        ? ack_word :
                     address == ADDR_IN_SERVICE ? insvc16 : 16'h0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            insvc_q    <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            insvc_q    <= insvc_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_sys_irq_ctrl.sv
// tb_sys_irq_ctrl: directed register/irq vectors with hand-computed expectations
module tb_sys_irq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_in = '0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic [15:0] v;
    int          n_vec = 0;
    int          n_err = 0;

    sys_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cycles(3);
        reset = 1'b0;
        cycles(2);
        // build up live state, then reset asynchronously mid-run
        wr_reg(3'd2, 16'h00FF);
        wr_reg(3'd1, 16'h00A5);
        irq_in = 8'hFF;
        cycles(5);
        chk("irq_before_reset", {15'b0, irq}, 16'h0001);
        #3 reset = 1'b1;
        #1 chk("irq_async_reset", {15'b0, irq}, 16'h0000);
        irq_in = 8'h00;
        cycles(2);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a), v);
            chk($sformatf("reset_rd%0d", a), v, 16'h0000);
        end
        chk("irq_after_reset", {15'b0, irq}, 16'h0000);

        wr_reg(3'd1, 16'h00A5);
        rd_reg(3'd1, v); chk("mask_a5", v, 16'h00A5);
        wr_reg(3'd1, 16'hFFFF);
        rd_reg(3'd1, v); chk("mask_ffff", v, 16'h00FF);
        wr_reg(3'd6, 16'hFFFF);
        rd_reg(3'd6, v); chk("addr6", v, 16'h0000);

        // edge latency: pulse line 0 for one cycle, watch PENDING via readdata each cycle
        wr_reg(3'd2, 16'h00FF);
        wr_reg(3'd1, 16'h0001);
        @(negedge clk); address = 3'd0; irq_in[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); irq_in[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("edge_irq_k2", {15'b0, irq}, 16'h0000);
        chk("edge_pend_k2", readdata, 16'h0000);
        @(posedge clk); #1;
        chk("edge_irq_k3", {15'b0, irq}, 16'h0001);
        chk("edge_pend_k3", readdata, 16'h0001);
        wr_reg(3'd0, 16'h0001);
        cycles(1);
        chk("w1c_irq", {15'b0, irq}, 16'h0000);
        rd_reg(3'd0, v); chk("w1c_pend", v, 16'h0000);

        // level mode: W1C has no effect, dropping the line clears
        wr_reg(3'd2, 16'h0000);
        wr_reg(3'd1, 16'h0010);
        irq_in[4] = 1'b1;
        cycles(4);
        rd_reg(3'd0, v); chk("lvl_pend", v, 16'h0010);
        chk("lvl_irq", {15'b0, irq}, 16'h0001);
        wr_reg(3'd0, 16'h0010);
        rd_reg(3'd0, v); chk("lvl_w1c", v, 16'h0010);
        irq_in[4] = 1'b0;
        cycles(4);
        chk("lvl_irq_drop", {15'b0, irq}, 16'h0000);
        rd_reg(3'd0, v); chk("lvl_pend_drop", v, 16'h0000);

        // priority and nesting
        wr_reg(3'd2, 16'h00FF);
        wr_reg(3'd1, 16'h00FF);
        irq_in = 8'h24;
        cycles(4);
        rd_reg(3'd3, v); chk("ack_rd_2", v, 16'h8002);
        chk("prio_irq", {15'b0, irq}, 16'h0001);
        wr_reg(3'd3, 16'h0002);
        rd_reg(3'd5, v); chk("insvc_2", v, 16'h0004);
        cycles(1);
        chk("blocked_irq", {15'b0, irq}, 16'h0000);
        rd_reg(3'd0, v); chk("pend_5", v, 16'h0020);
        irq_in = 8'h26;
        cycles(4);
        chk("preempt_irq", {15'b0, irq}, 16'h0001);
        rd_reg(3'd3, v); chk("ack_rd_1", v, 16'h8001);
        wr_reg(3'd3, 16'h0001);
        cycles(2);
        chk("nest_irq", {15'b0, irq}, 16'h0000);
        rd_reg(3'd5, v); chk("insvc_6", v, 16'h0006);
        wr_reg(3'd4, 16'h0002);
        cycles(2);
        chk("eoi2_irq", {15'b0, irq}, 16'h0000);
        rd_reg(3'd5, v); chk("insvc_eoi2", v, 16'h0002);
        wr_reg(3'd4, 16'h0001);
        cycles(2);
        chk("eoi1_irq", {15'b0, irq}, 16'h0001);
        rd_reg(3'd4, v); chk("eoi_rd", v, 16'h0000);
        wr_reg(3'd0, 16'h00FF);
        irq_in = 8'h00;
        cycles(4);
        chk("clean_irq", {15'b0, irq}, 16'h0000);

        // collision: W1C lands on the same edge as the rise detect of line 3
        @(negedge clk); irq_in[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr_reg(3'd0, 16'h0008);
        rd_reg(3'd0, v); chk("collide_set_wins", v, 16'h0008);
        wr_reg(3'd0, 16'h0008);
        rd_reg(3'd0, v); chk("collide_clear", v, 16'h0000);

        // illegal indices
        irq_in[6] = 1'b1;
        cycles(4);
        wr_reg(3'd3, 16'h0002);
        wr_reg(3'd4, 16'h000C);
        rd_reg(3'd5, v); chk("eoi12_insvc", v, 16'h0004);
        wr_reg(3'd3, 16'h000C);
        rd_reg(3'd5, v); chk("ack12_insvc", v, 16'h0004);
        rd_reg(3'd0, v); chk("ack12_pend", v, 16'h0040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
